// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sequencer that time-shares one combinational
// RV32 ALU between two requesters through valid/ready handshakes.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   r{0,1}_valid/_ready      request handshake (ready is combinational)
//   r{0,1}_opA/_opB/_sel     request operands and ALU select code
//   r{0,1}_rsp_valid/_ready  response handshake with backpressure
//   r{0,1}_rsp_data/_rsp_err response payload (data 0 and err 1 on illegal sel)
//   alu_opA/_opB/_sel        registered operands driven into the shared ALU
//   alu_out                  ALU result, combinational from alu_* outputs
module alu_share_arbiter #(
  parameter int unsigned     XLEN    = 32,
  parameter int unsigned     SELW    = 4,
  parameter logic [SELW-1:0] MAX_SEL = SELW'(4'b1001)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            r0_valid,
  output logic            r0_ready,
  input  logic [XLEN-1:0] r0_opA,
  input  logic [XLEN-1:0] r0_opB,
  input  logic [SELW-1:0] r0_sel,
  output logic            r0_rsp_valid,
  input  logic            r0_rsp_ready,
  output logic [XLEN-1:0] r0_rsp_data,
  output logic            r0_rsp_err,
  input  logic            r1_valid,
  output logic            r1_ready,
  input  logic [XLEN-1:0] r1_opA,
  input  logic [XLEN-1:0] r1_opB,
  input  logic [SELW-1:0] r1_sel,
  output logic            r1_rsp_valid,
  input  logic            r1_rsp_ready,
  output logic [XLEN-1:0] r1_rsp_data,
  output logic            r1_rsp_err,
  output logic [XLEN-1:0] alu_opA,
  output logic [XLEN-1:0] alu_opB,
  output logic [SELW-1:0] alu_sel,
  input  logic [XLEN-1:0] alu_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic            r_last_grant;
  logic            r_owner;
  logic            r_err;
  logic [XLEN-1:0] r_opA;
  logic [XLEN-1:0] r_opB;
  logic [SELW-1:0] r_sel;
  logic [XLEN-1:0] r_result;

  logic            w_grant;
  logic            w_accept;
  logic            w_illegal;
  logic            w_rsp_ready;
  logic            w_in_resp;
  logic [XLEN-1:0] w_opA;
  logic [XLEN-1:0] w_opB;
  logic [SELW-1:0] w_sel;

  // Grant selection: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    w_grant = 1'b0;
    if (r0_valid && r1_valid) begin
      w_grant = ~r_last_grant;
    end else if (r1_valid) begin
      w_grant = 1'b1;
    end
    w_accept    = (r_state == S_IDLE) && (r0_valid || r1_valid);
    w_opA       = w_grant ? r1_opA : r0_opA;
    w_opB       = w_grant ? r1_opB : r0_opB;
    w_sel       = w_grant ? r1_sel : r0_sel;
    w_illegal   = (w_sel > MAX_SEL);
    w_rsp_ready = r_owner ? r1_rsp_ready : r0_rsp_ready;
    w_in_resp   = (r_state == S_RESP);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; illegal selects skip the ALU and go straight to RESP.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = w_illegal ? S_RESP : S_EXEC;
        end
      end
      S_EXEC: w_next_state = S_RESP;
      S_RESP: begin
        if (w_rsp_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Operand, ownership and result registers; ALU operands are left untouched on illegal ops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_err        <= 1'b0;
      r_opA        <= '0;
      r_opB        <= '0;
      r_sel        <= '0;
      r_result     <= '0;
    end else begin
      if (w_accept) begin
        r_owner      <= w_grant;
        r_last_grant <= w_grant;
        if (w_illegal) begin
          r_result <= '0;
          r_err    <= 1'b1;
        end else begin
          r_opA <= w_opA;
          r_opB <= w_opB;
          r_sel <= w_sel;
          r_err <= 1'b0;
        end
      end
      if (r_state == S_EXEC) begin
        r_result <= alu_out;
        r_err    <= 1'b0;
      end
    end
  end

  assign r0_ready     = w_accept && !w_grant;
  assign r1_ready     = w_accept && w_grant;
  assign r0_rsp_valid = w_in_resp && !r_owner;
  assign r1_rsp_valid = w_in_resp && r_owner;
  // Data holds its last value outside RESP; err is qualified by the response valid.
  assign r0_rsp_data  = r_result;
  assign r1_rsp_data  = r_result;
  assign r0_rsp_err   = r_err && r0_rsp_valid;
  assign r1_rsp_err   = r_err && r1_rsp_valid;
  assign alu_opA      = r_opA;
  assign alu_opB      = r_opB;
  assign alu_sel      = r_sel;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: reset, tie/round-robin,
// table-driven op stream, backpressure, mid-op reset, random scoreboard.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  valid;
  logic [1:0]  ready;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [1:0]  rsp_err;
  logic [31:0] opA [2];
  logic [31:0] opB [2];
  logic [3:0]  sel [2];
  logic [31:0] rsp_data [2];
  logic [31:0] alu_opA;
  logic [31:0] alu_opB;
  logic [3:0]  alu_sel;
  logic [31:0] alu_out;

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;
  logic [31:0] last_a, last_b;
  logic [3:0]  last_s;

  typedef struct {
    int          port;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];

  alu_share_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .r0_valid     (valid[0]),
    .r0_ready     (ready[0]),
    .r0_opA       (opA[0]),
    .r0_opB       (opB[0]),
    .r0_sel       (sel[0]),
    .r0_rsp_valid (rsp_valid[0]),
    .r0_rsp_ready (rsp_ready[0]),
    .r0_rsp_data  (rsp_data[0]),
    .r0_rsp_err   (rsp_err[0]),
    .r1_valid     (valid[1]),
    .r1_ready     (ready[1]),
    .r1_opA       (opA[1]),
    .r1_opB       (opB[1]),
    .r1_sel       (sel[1]),
    .r1_rsp_valid (rsp_valid[1]),
    .r1_rsp_ready (rsp_ready[1]),
    .r1_rsp_data  (rsp_data[1]),
    .r1_rsp_err   (rsp_err[1]),
    .alu_opA      (alu_opA),
    .alu_opB      (alu_opB),
    .alu_sel      (alu_sel),
    .alu_out      (alu_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  // Behavioural RV32 ALU; codes above 1001 return a marker that must never surface.
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] s);
    case (s)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a << b[4:0];
      4'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:    return (a < b) ? 32'd1 : 32'd0;
      4'd5:    return a ^ b;
      4'd6:    return a >> b[4:0];
      4'd7:    return 32'($signed(a) >>> b[4:0]);
      4'd8:    return a | b;
      4'd9:    return a & b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_out = alu_ref(alu_opA, alu_opB, alu_sel);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // One op through a single port with rsp_ready high; returns the accept cycle.
  task automatic do_op(input vec_t v, output int acc_cyc);
    int p;
    int q;
    p = v.port;
    q = 1 - v.port;
    valid[p] = 1'b1;
    opA[p]   = v.a;
    opB[p]   = v.b;
    sel[p]   = v.sel;
    @(negedge clk);
    chk("op_ready", 32'(ready[p]), 32'd1);
    chk("op_other_ready", 32'(ready[q]), 32'd0);
    acc_cyc = ncyc;
    @(posedge clk);
    #1;
    valid[p] = 1'b0;
    @(negedge clk);
    chk("op_ready_pulse", 32'(ready[p]), 32'd0);
    if (!v.exp_err) begin
      chk("op_alu_opA", alu_opA, v.a);
      chk("op_alu_opB", alu_opB, v.b);
      chk("op_alu_sel", 32'(alu_sel), 32'(v.sel));
      chk("op_exec_rsp_valid", 32'(rsp_valid[p]), 32'd0);
      @(negedge clk);
    end else begin
      chk("ill_alu_opA", alu_opA, last_a);
      chk("ill_alu_opB", alu_opB, last_b);
      chk("ill_alu_sel", 32'(alu_sel), 32'(last_s));
    end
    chk("op_rsp_valid", 32'(rsp_valid[p]), 32'd1);
    chk("op_other_rsp_valid", 32'(rsp_valid[q]), 32'd0);
    chk("op_rsp_data", rsp_data[p], v.exp_data);
    chk("op_rsp_err", 32'(rsp_err[p]), 32'(v.exp_err));
    if (!v.exp_err) begin
      last_a = v.a;
      last_b = v.b;
      last_s = v.sel;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int prev_acc;
    int got;
    int busy;
    int owner;
    int rcyc;
    int last;
    int c;
    int g;
    int nresp;
    logic        legal;
    logic [31:0] ed;
    logic        ee;
    logic [1:0]  exp_v;
    logic [1:0]  clr;

    vecs[0]  = '{0, 32'd5,          32'd1,          4'b0000, 32'd6,          1'b0};
    vecs[1]  = '{1, 32'd7,          32'd4,          4'b0001, 32'd3,          1'b0};
    vecs[2]  = '{0, 32'd1,          32'd4,          4'b0010, 32'd16,         1'b0};
    vecs[3]  = '{1, 32'hFFFF_FFFF,  32'd1,          4'b0011, 32'd1,          1'b0};
    vecs[4]  = '{0, 32'hFFFF_FFFF,  32'd1,          4'b0100, 32'd0,          1'b0};
    vecs[5]  = '{1, 32'h0000_F0F0,  32'h0000_0FF0,  4'b0101, 32'h0000_FF00,  1'b0};
    vecs[6]  = '{0, 32'h8000_0000,  32'd4,          4'b0110, 32'h0800_0000,  1'b0};
    vecs[7]  = '{1, 32'h8000_0000,  32'd4,          4'b0111, 32'hF800_0000,  1'b0};
    vecs[8]  = '{0, 32'h0000_00F0,  32'h0000_000F,  4'b1000, 32'h0000_00FF,  1'b0};
    vecs[9]  = '{1, 32'h0000_00F0,  32'h0000_00FC,  4'b1001, 32'h0000_00F0,  1'b0};
    vecs[10] = '{0, 32'd8,          32'd3,          4'b1010, 32'd0,          1'b1};
    vecs[11] = '{1, 32'd1,          32'd2,          4'b1111, 32'd0,          1'b1};

    rst = 1'b1;
    valid = 2'b00;
    rsp_ready = 2'b11;
    for (int k = 0; k < 2; k++) begin
      opA[k] = '0;
      opB[k] = '0;
      sel[k] = '0;
    end
    last_a = '0;
    last_b = '0;
    last_s = '0;

    // Reset state
    #2;
    chk("rst_alu_opA", alu_opA, 32'd0);
    chk("rst_alu_opB", alu_opB, 32'd0);
    chk("rst_alu_sel", 32'(alu_sel), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_data0", rsp_data[0], 32'd0);
    chk("rst_rsp_data1", rsp_data[1], 32'd0);
    #10;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Tie from reset, then alternation with both held valid
    valid  = 2'b11;
    opA[0] = 32'd7;  opB[0] = 32'd4;  sel[0] = 4'b0001;
    opA[1] = 32'd38; opB[1] = 32'd33; sel[1] = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      got = -1;
      for (int t = 0; t < 10 && got < 0; t++) begin
        @(negedge clk);
        if (ready[0]) got = 0;
        else if (ready[1]) got = 1;
      end
      chk("rr_grant", 32'(got), 32'(k % 2));
      if (got >= 0) begin
        chk("rr_single_ready", 32'(ready), (got == 0) ? 32'd1 : 32'd2);
        acc = 0;
        for (int t = 0; t < 10 && acc == 0; t++) begin
          @(negedge clk);
          if (rsp_valid[got]) acc = 1;
        end
        chk("rr_rsp_seen", 32'(acc), 32'd1);
        chk("rr_rsp_data", rsp_data[got], (got == 0) ? 32'd3 : 32'd71);
      end
    end
    @(posedge clk);
    #1;
    valid  = 2'b00;
    last_a = 32'd38;
    last_b = 32'd33;
    last_s = 4'b0000;

    // Table-driven stream, alternating ports, with throughput check
    prev_acc = 0;
    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i], acc);
      if (i > 0) begin
        chk("stream_interval", 32'(acc - prev_acc), vecs[i-1].exp_err ? 32'd2 : 32'd3);
      end
      prev_acc = acc;
    end

    // Backpressure on r1 with r0 waiting
    rsp_ready = 2'b01;
    valid[1] = 1'b1;
    opA[1] = 32'd100; opB[1] = 32'd23; sel[1] = 4'b0000;
    @(negedge clk);
    chk("bp_r1_ready", 32'(ready[1]), 32'd1);
    @(posedge clk);
    #1;
    valid[1] = 1'b0;
    valid[0] = 1'b1;
    opA[0] = 32'd2; opB[0] = 32'd2; sel[0] = 4'b0000;
    @(negedge clk);
    chk("bp_exec_r0_ready", 32'(ready[0]), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(rsp_valid[1]), 32'd1);
      chk("bp_hold_data", rsp_data[1], 32'd123);
      chk("bp_hold_r0_ready", 32'(ready[0]), 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    chk("bp_consume_valid", 32'(rsp_valid[1]), 32'd1);
    chk("bp_same_cycle_r0_ready", 32'(ready[0]), 32'd0);
    @(negedge clk);
    chk("bp_idle_r0_ready", 32'(ready[0]), 32'd1);
    chk("bp_r1_rsp_gone", 32'(rsp_valid[1]), 32'd0);
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_r0_rsp_valid", 32'(rsp_valid[0]), 32'd1);
    chk("bp_r0_rsp_data", rsp_data[0], 32'd4);
    @(posedge clk);
    #1;

    // Asynchronous reset while in EXEC
    valid[0] = 1'b1;
    opA[0] = 32'd9; opB[0] = 32'd9; sel[0] = 4'b0000;
    @(negedge clk);
    chk("mr_ready", 32'(ready[0]), 32'd1);
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mr_alu_opA", alu_opA, 32'd0);
    chk("mr_alu_opB", alu_opB, 32'd0);
    chk("mr_alu_sel", 32'(alu_sel), 32'd0);
    chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mr_rsp_err", 32'(rsp_err), 32'd0);
    chk("mr_rsp_data0", rsp_data[0], 32'd0);
    chk("mr_ready", 32'(ready), 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mr_no_rsp", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    valid = 2'b11;
    opA[0] = 32'd1; opB[0] = 32'd1; sel[0] = 4'b0000;
    opA[1] = 32'd2; opB[1] = 32'd2; sel[1] = 4'b0000;
    @(negedge clk);
    chk("mr_tie_ready", 32'(ready), 32'd1);
    @(posedge clk);
    #1;
    valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk("mr_tie_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("mr_tie_rsp_data", rsp_data[0], 32'd2);
    @(posedge clk);
    #1;

    // Random traffic against a transaction-level scoreboard
    busy  = 0;
    owner = 0;
    rcyc  = 0;
    last  = 0;
    c     = 0;
    nresp = 0;
    ed    = '0;
    ee    = 1'b0;
    clr   = 2'b00;
    for (int it = 0; it < 1500; it++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (clr[k]) begin
          valid[k] = 1'b0;
        end else if (!valid[k] && $urandom_range(0, 1) == 1) begin
          valid[k] = 1'b1;
          opA[k]   = $urandom;
          opB[k]   = $urandom;
          sel[k]   = 4'($urandom_range(0, 15));
        end
        rsp_ready[k] = ($urandom_range(0, 9) < 7);
      end
      clr = 2'b00;
      @(negedge clk);
      c++;
      if (busy == 0) begin
        exp_v = 2'b00;
        g = 0;
        if (valid != 2'b00) begin
          g = (valid == 2'b11) ? (1 - last) : (valid[1] ? 1 : 0);
          exp_v[g] = 1'b1;
        end
        chk("rnd_ready", 32'(ready), 32'(exp_v));
        chk("rnd_idle_rsp_valid", 32'(rsp_valid), 32'd0);
        if (valid != 2'b00) begin
          busy  = 1;
          owner = g;
          last  = g;
          legal = (sel[g] <= 4'd9);
          ed    = legal ? alu_ref(opA[g], opB[g], sel[g]) : 32'd0;
          ee    = !legal;
          rcyc  = c + (legal ? 2 : 1);
          clr[g] = 1'b1;
        end
      end else begin
        chk("rnd_busy_ready", 32'(ready), 32'd0);
        exp_v = 2'b00;
        if (c >= rcyc) exp_v[owner] = 1'b1;
        chk("rnd_rsp_valid", 32'(rsp_valid), 32'(exp_v));
        if (c >= rcyc) begin
          chk("rnd_rsp_data", rsp_data[owner], ed);
          chk("rnd_rsp_err", 32'(rsp_err[owner]), 32'(ee));
          if (rsp_ready[owner]) begin
            busy = 0;
            nresp++;
          end
        end
      end
    end
    valid = 2'b00;
    chk("rnd_some_responses", 32'(nresp > 100), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Sequencing arbiter that time-shares the single combinational RV32 ALU (32-bit opA/opB, 4-bit aluOutSel, 32-bit aluOut) between two requesters, e.g. the execute stage (port 0) and the branch/address unit (port 1). It accepts one operation at a time through a valid/ready handshake and grants round-robin. It drives registered operands into the ALU, captures the result, and returns it on the granted requester's response channel with backpressure. Select codes outside the legal set are rejected with an error response and are never issued to the ALU.

## Interface
Parameters:
- XLEN, 32, operand/result width
- SELW, 4, ALU select width
- MAX_SEL, 4'b1001, highest legal ALU select code; codes above it are illegal

Ports (k = 0, 1; one identical set per requester). One clock; reset is asynchronous and active-high.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- rk_valid  input  1  request k valid
- rk_ready  output  1  request k accepted this cycle
- rk_opA  input  XLEN  operand A
- rk_opB  input  XLEN  operand B
- rk_sel  input  SELW  ALU select code
- rk_rsp_valid  output  1  response k valid
- rk_rsp_ready  input  1  requester k consumes response
- rk_rsp_data  output  XLEN  ALU result (0 on error)
- rk_rsp_err  output  1  illegal select code
- alu_opA  output  XLEN  registered operand A to ALU
- alu_opB  output  XLEN  registered operand B to ALU
- alu_sel  output  SELW  registered select to ALU
- alu_out  input  XLEN  ALU result (combinational from alu_* outputs)

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - rk_ready = 1 only for the granted requester and only when its rk_valid = 1 (combinational); at most one ready high.
  - Grant: if exactly one valid, grant it. If both valid, grant the requester not in last_grant.
  - On an accepting edge: latch opA/opB/sel into the alu_* registers, record the owner, set last_grant = owner.
  - Legal sel -> EXEC. Illegal sel (> MAX_SEL) -> RESP with result 0 and err = 1; the alu_* registers stay unchanged and the ALU is not issued.
- EXEC: one cycle. alu_out is captured into the result register at the edge, err = 0, -> RESP.
- RESP:
  - Owner's rk_rsp_valid = 1, with rk_rsp_data and rk_rsp_err held stable. The other requester's rsp_valid = 0.
  - An edge with rk_rsp_ready = 1 -> IDLE. Otherwise hold indefinitely.
- No new request is accepted while in EXEC or RESP; all rk_ready = 0 there.
- Operands pass to the ALU unmodified. Width, overflow and shift rules belong to the ALU; the arbiter does not alter alu_out.

## Timing
- Reset (async, any state): state = IDLE, last_grant = 1 (requester 0 wins the first tie), alu_opA = alu_opB = 0, alu_sel = 0, result = 0, err = 0, all rk_ready/rk_rsp_valid/rk_rsp_err = 0, rk_rsp_data = 0.
- Reset asserted mid-operation discards the in-flight operation and any pending response; no response is ever produced for it.
- Latency, legal op: accept at edge N; result captured at edge N+1; rk_rsp_valid high from after edge N+1.
- Latency, illegal op: rk_rsp_valid high from after edge N.
- Throughput with rsp_ready tied high: one legal op per 3 cycles; one illegal op per 2 cycles.
- A request held valid and not granted must stay stable until accepted; the arbiter does not require this but is verified only under it.
- rsp_ready asserted while rsp_valid = 0 is ignored.
- Simultaneous events: the response being consumed and a new request presented in the same cycle -> the request is not accepted until the following IDLE cycle.
- rk_rsp_data is guaranteed only while rk_rsp_valid = 1; it holds its last value otherwise.

## Test plan
- Single op: r0 sends opA=5, opB=1, sel=0000 (add), rsp_ready=1 -> r0_ready pulses one cycle; alu_opA=5/alu_opB=1 one cycle later; r0_rsp_valid=1 with data=6, err=0 two cycles after accept; r1 sees no response.
- Tie and round-robin: both valid from reset with r0 (7, 4, 0001 sub) and r1 (38, 33, 0000) -> r0 is served first (data=3), then r1 (data=71); with both held valid, grants alternate 0,1,0,1 over 4 ops.
- Backpressure: r1 op completes with r1_rsp_ready=0 for 5 cycles -> rsp_valid and data are held stable for 5 cycles and r0_ready stays 0; ready high -> IDLE next cycle, and r0 is accepted in that IDLE cycle.
- Illegal select: r0 sel=1010, operands 8/3 -> response one cycle after accept with data=0, err=1; alu_sel and alu_opA/alu_opB are unchanged from the prior op.
- Reset mid-op: assert rst asynchronously (between edges) while in EXEC -> all outputs reach reset values immediately; no response is issued after release; the next tie grants r0.
- Back-to-back stream: 10 ops alternating requesters (sel 0000-1001) with rsp_ready=1 -> each result matches the ALU model; exactly 3 cycles per op; zero lost or duplicated responses.
